// File: rtl/trap_sequencer.sv
// trap_sequencer
// Machine-mode trap / mret sequencer. Watches the commit stage for ecall,
// mret and an enabled+pending timer interrupt, then drives the CSR file's
// trap-side write port (mepc, mcause, mstatus) and redirects fetch.
// The trap port yields to in-flight CPU CSR writes; the pipeline is stalled
// for the whole sequence.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   commit_valid_i             an instruction retires this cycle
//   commit_pc_i                PC of the retiring instruction
//   commit_next_pc_i           resolved next PC of the retiring instruction
//   ecall_i, mret_i            retiring instruction kind (qualified by commit_valid_i)
//   cpu_csr_wen_i              CPU CSR write in flight (trap port must wait)
//   global_int_en_i            mstatus.MIE
//   mtime_int_en_i             mie.MTIE
//   mtime_int_pend_i           mip.MTIP
//   mtvec_i, mepc_i, mstatus_i current CSR values
//   mepc_*/mcause_*/mstatus_*  CSR write ports (enable + data)
//   redirect_valid_o/pc_o      one-cycle fetch redirect
//   stall_o                    hold pipeline
module trap_sequencer #(
    parameter int XLEN        = 64,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic [XLEN-1:0] commit_next_pc_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic            cpu_csr_wen_i,
    input  logic            global_int_en_i,
    input  logic            mtime_int_en_i,
    input  logic            mtime_int_pend_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mstatus_i,
    output logic            mepc_wen_o,
    output logic [XLEN-1:0] mepc_wdata_o,
    output logic            mcause_wen_o,
    output logic [XLEN-1:0] mcause_wdata_o,
    output logic            mstatus_wen_o,
    output logic [XLEN-1:0] mstatus_wdata_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            stall_o
);

    typedef enum logic [1:0] {IDLE, ARB, WRITE, REDIRECT} state_t;

    localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_MTI   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);

    state_t state, state_nxt;

    // captured event
    logic            is_mret_q;
    logic            is_int_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] cause_q;

    // registered write data / last redirect target
    logic [XLEN-1:0] mepc_wdata_q, mcause_wdata_q, mstatus_wdata_q, redir_pc_q;

    // ---------------- event detection (IDLE only, ecall > mret > irq)
    logic idle, int_hit, ev_ecall, ev_mret, ev_int, ev_any;
    assign idle     = (state == IDLE);
    assign int_hit  = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    assign ev_ecall = idle & commit_valid_i & ecall_i;
    assign ev_mret  = idle & commit_valid_i & mret_i & ~ecall_i;
    assign ev_int   = idle & commit_valid_i & int_hit & ~ecall_i & ~mret_i;
    assign ev_any   = ev_ecall | ev_mret | ev_int;

    // ARB exits only on a cycle where the CSR file will accept trap writes
    logic arb_go;
    assign arb_go = (state == ARB) & ~cpu_csr_wen_i;

    // ---------------- FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (ev_any) state_nxt = ARB;
            ARB:      if (arb_go) state_nxt = WRITE;
            WRITE:    state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // ---------------- mstatus update functions
    logic [XLEN-1:0] mstatus_trap, mstatus_mret;
    always_comb begin
        mstatus_trap        = mstatus_i;
        mstatus_trap[7]     = mstatus_i[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_mret        = mstatus_i;
        mstatus_mret[3]     = mstatus_i[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
    end

    // ---------------- redirect target (sampled live in REDIRECT so an
    // mret sees the mepc value after any earlier write has landed)
    logic [XLEN-1:0] base, trap_tgt, tgt;
    logic            vec;
    always_comb begin
        base     = {mtvec_i[XLEN-1:2], 2'b00};
        vec      = VECTORED_EN && (mtvec_i[1:0] == 2'b01) && is_int_q;
        trap_tgt = vec ? base + XLEN'(28) : base;
        tgt      = is_mret_q ? mepc_i : trap_tgt;
    end

    // ---------------- datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_mret_q       <= 1'b0;
            is_int_q        <= 1'b0;
            epc_q           <= '0;
            cause_q         <= '0;
            mepc_wdata_q    <= '0;
            mcause_wdata_q  <= '0;
            mstatus_wdata_q <= '0;
            redir_pc_q      <= '0;
        end else begin
            if (ev_any) begin
                is_mret_q <= ev_mret;
                is_int_q  <= ev_int;
                epc_q     <= ev_int ? {commit_next_pc_i[XLEN-1:2], 2'b00}
                                    : {commit_pc_i[XLEN-1:2], 2'b00};
                cause_q   <= ev_int ? CAUSE_MTI : CAUSE_ECALL;
            end
            if (arb_go) begin
                if (is_mret_q) begin
                    mstatus_wdata_q <= mstatus_mret;
                end else begin
                    mepc_wdata_q    <= epc_q;
                    mcause_wdata_q  <= cause_q;
                    mstatus_wdata_q <= mstatus_trap;
                end
            end
            if (state == REDIRECT) redir_pc_q <= tgt;
        end
    end

    // ---------------- FSM: outputs (strobes decode the state register only)
    always_comb begin
        mepc_wen_o       = 1'b0;
        mcause_wen_o     = 1'b0;
        mstatus_wen_o    = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = redir_pc_q;
        case (state)
            WRITE: begin
                mepc_wen_o    = ~is_mret_q;
                mcause_wen_o  = ~is_mret_q;
                mstatus_wen_o = 1'b1;
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = tgt;
            end
            default: ;
        endcase
    end

    assign mepc_wdata_o    = mepc_wdata_q;
    assign mcause_wdata_o  = mcause_wdata_q;
    assign mstatus_wdata_o = mstatus_wdata_q;
    assign stall_o         = ~idle | ev_any;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer. A second instance with VECTORED_EN=0
// shares all inputs so the direct-mode redirect can be checked alongside.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid, ecall, mret, cpu_wen, gie, mtie, mtip;
    logic [63:0] pc, next_pc, mtvec, mepc, mstatus;

    logic        mepc_wen, mcause_wen, mstatus_wen, rv, stall;
    logic [63:0] mepc_wd, mcause_wd, mstatus_wd, rpc;
    logic        n_mepc_wen, n_mcause_wen, n_mstatus_wen, n_rv, n_stall;
    logic [63:0] n_mepc_wd, n_mcause_wd, n_mstatus_wd, n_rpc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(64), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_i(commit_valid), .commit_pc_i(pc), .commit_next_pc_i(next_pc),
        .ecall_i(ecall), .mret_i(mret), .cpu_csr_wen_i(cpu_wen),
        .global_int_en_i(gie), .mtime_int_en_i(mtie), .mtime_int_pend_i(mtip),
        .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_i(mstatus),
        .mepc_wen_o(mepc_wen), .mepc_wdata_o(mepc_wd),
        .mcause_wen_o(mcause_wen), .mcause_wdata_o(mcause_wd),
        .mstatus_wen_o(mstatus_wen), .mstatus_wdata_o(mstatus_wd),
        .redirect_valid_o(rv), .redirect_pc_o(rpc), .stall_o(stall)
    );

    trap_sequencer #(.XLEN(64), .VECTORED_EN(1'b0)) dut_nv (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_i(commit_valid), .commit_pc_i(pc), .commit_next_pc_i(next_pc),
        .ecall_i(ecall), .mret_i(mret), .cpu_csr_wen_i(cpu_wen),
        .global_int_en_i(gie), .mtime_int_en_i(mtie), .mtime_int_pend_i(mtip),
        .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_i(mstatus),
        .mepc_wen_o(n_mepc_wen), .mepc_wdata_o(n_mepc_wd),
        .mcause_wen_o(n_mcause_wen), .mcause_wdata_o(n_mcause_wd),
        .mstatus_wen_o(n_mstatus_wen), .mstatus_wdata_o(n_mstatus_wd),
        .redirect_valid_o(n_rv), .redirect_pc_o(n_rpc), .stall_o(n_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobes as a packed nibble: {mepc_wen, mcause_wen, mstatus_wen, redirect_valid}
    function automatic logic [63:0] strb();
        return {60'd0, mepc_wen, mcause_wen, mstatus_wen, rv};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; commit_valid = 0; ecall = 0; mret = 0; cpu_wen = 0;
        gie = 0; mtie = 0; mtip = 0;
        pc = '0; next_pc = '0; mtvec = '0; mepc = '0; mstatus = '0;
        step(); step();

        // ---- reset state
        chk("rst_strobes", strb(), 64'h0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_mepc_wd", mepc_wd, 64'h0);
        chk("rst_mcause_wd", mcause_wd, 64'h0);
        chk("rst_mstatus_wd", mstatus_wd, 64'h0);
        chk("rst_rpc", rpc, 64'h0);
        rst_n = 1'b1;
        step();

        // ---- ecall, no arbitration stall
        commit_valid = 1; ecall = 1; pc = 64'h8000_0010; next_pc = 64'h8000_0014;
        mtvec = 64'h8000_1001; mstatus = 64'h1888;
        #1 chk("ecall_detect_stall", {63'd0, stall}, 64'd1);
        step(); commit_valid = 0; ecall = 0;                 // ARB
        #1 chk("ecall_arb_strobes", strb(), 64'h0);
        chk("ecall_arb_stall", {63'd0, stall}, 64'd1);
        step();                                              // WRITE
        chk("ecall_wr_strobes", strb(), 64'he);
        chk("ecall_mepc", mepc_wd, 64'h8000_0010);
        chk("ecall_mcause", mcause_wd, 64'd11);
        chk("ecall_mstatus", mstatus_wd, 64'h1880);
        step();                                              // REDIRECT
        chk("ecall_rd_strobes", strb(), 64'h1);
        chk("ecall_rpc", rpc, 64'h8000_1000);
        chk("ecall_rd_stall", {63'd0, stall}, 64'd1);
        step();                                              // IDLE
        chk("ecall_idle_strobes", strb(), 64'h0);
        chk("ecall_idle_stall", {63'd0, stall}, 64'd0);
        chk("ecall_rpc_hold", rpc, 64'h8000_1000);

        // ---- timer interrupt, vectored vs direct
        commit_valid = 1; pc = 64'h8000_0100; next_pc = 64'h8000_0104;
        gie = 1; mtie = 1; mtip = 1; mtvec = 64'h8000_2001; mstatus = 64'h1888;
        #1 chk("int_detect_stall", {63'd0, stall}, 64'd1);
        step(); commit_valid = 0; mtip = 0;
        step();                                              // WRITE
        chk("int_wr_strobes", strb(), 64'he);
        chk("int_mepc", mepc_wd, 64'h8000_0104);
        chk("int_mcause", mcause_wd, 64'h8000_0000_0000_0007);
        chk("int_mstatus", mstatus_wd, 64'h1880);
        chk("int_nv_mcause", n_mcause_wd, 64'h8000_0000_0000_0007);
        chk("int_nv_wen", {61'd0, n_mepc_wen, n_mcause_wen, n_mstatus_wen}, 64'h7);
        chk("int_nv_data", n_mepc_wd ^ n_mstatus_wd, 64'h8000_0104 ^ 64'h1880);
        step();                                              // REDIRECT
        chk("int_rpc_vec", rpc, 64'h8000_201C);
        chk("int_rpc_direct", n_rpc, 64'h8000_2000);
        chk("int_nv_rv", {62'd0, n_rv, n_stall}, 64'h3);
        step();
        chk("int_idle_stall", {63'd0, stall}, 64'd0);

        // ---- mret
        gie = 0; mtie = 0;
        commit_valid = 1; mret = 1; mstatus = 64'h1880; mepc = 64'h8000_0104;
        step(); commit_valid = 0; mret = 0;
        step();                                              // WRITE
        chk("mret_wr_strobes", strb(), 64'h2);
        chk("mret_mstatus", mstatus_wd, 64'h1888);
        chk("mret_mepc_wd_hold", mepc_wd, 64'h8000_0104);
        step();                                              // REDIRECT
        chk("mret_rd_strobes", strb(), 64'h1);
        chk("mret_rpc", rpc, 64'h8000_0104);
        step();

        // ---- ecall held off by CPU CSR writes for 3 cycles
        commit_valid = 1; ecall = 1; pc = 64'h8000_0200; mtvec = 64'h8000_1000;
        mstatus = 64'h1888;
        step(); commit_valid = 0; ecall = 0; cpu_wen = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("arb_hold_strobes", strb(), 64'h0);
            chk("arb_hold_stall", {63'd0, stall}, 64'd1);
            step();
        end
        cpu_wen = 0; mstatus = 64'h0;                        // sampled on ARB exit
        #1 chk("arb_release_strobes", strb(), 64'h0);
        chk("arb_release_stall", {63'd0, stall}, 64'd1);
        step();                                              // WRITE
        chk("arb_wr_strobes", strb(), 64'he);
        chk("arb_mepc", mepc_wd, 64'h8000_0200);
        chk("arb_mstatus", mstatus_wd, 64'h1800);
        step();
        chk("arb_rpc", rpc, 64'h8000_1000);
        step();

        // ---- ecall + interrupt same cycle: ecall wins, not vectored
        commit_valid = 1; ecall = 1; gie = 1; mtie = 1; mtip = 1;
        pc = 64'h8000_0300; next_pc = 64'h8000_0304; mtvec = 64'h8000_2001;
        mstatus = 64'h1888;
        step(); commit_valid = 0; ecall = 0; mtip = 0;
        step();
        chk("both_mcause", mcause_wd, 64'd11);
        chk("both_mepc", mepc_wd, 64'h8000_0300);
        step();
        chk("both_rpc", rpc, 64'h8000_2000);
        step();

        // ---- interrupt with MIE=0 ignored
        gie = 0; mtie = 1; mtip = 1; commit_valid = 1;
        #1 chk("noint_stall_det", {63'd0, stall}, 64'd0);
        step();
        chk("noint_stall_next", {63'd0, stall}, 64'd0);
        chk("noint_strobes", strb(), 64'h0);
        commit_valid = 0; mtip = 0; mtie = 0;
        step(); step();
        chk("noint_strobes2", strb(), 64'h0);

        // ---- reset during WRITE of a trap
        commit_valid = 1; ecall = 1; pc = 64'h8000_0400; mtvec = 64'h8000_1000;
        mstatus = 64'h1888;
        step(); commit_valid = 0; ecall = 0;
        step();                                              // WRITE
        chk("rstw_wr_strobes", strb(), 64'he);
        rst_n = 0;
        step();
        chk("rstw_strobes", strb(), 64'h0);
        chk("rstw_stall", {63'd0, stall}, 64'd0);
        chk("rstw_data", mepc_wd | mcause_wd | mstatus_wd | rpc, 64'h0);
        rst_n = 1;
        step();
        chk("rstw_no_redirect", strb(), 64'h0);
        step();
        chk("rstw_no_redirect2", strb(), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
